// File: rtl/crc32_pkg.sv
// Shared constants, state encoding and bit-reversal helpers
// for the byte-serial CRC-32 engine.
package crc32_pkg;

    localparam int CRC_W = 32;
    localparam int DATA_W = 8;
    localparam logic [CRC_W-1:0] CRC_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    function automatic logic [DATA_W-1:0] rev8(
        input logic [DATA_W-1:0] v
    );
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] rev32(
        input logic [CRC_W-1:0] v
    );
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_bitstep.sv
// One MSB-first LFSR step: absorbs a single data bit into the CRC.
module crc32_bitstep
    import crc32_pkg::*;
(
    input  logic [CRC_W-1:0] crc_in,
    input  logic             data_bit,
    input  logic [CRC_W-1:0] poly,
    output logic [CRC_W-1:0] crc_nx
);

    logic fb;

    assign fb = crc_in[CRC_W-1] ^ data_bit;

    assign crc_nx = {crc_in[CRC_W-2:0], 1'b0}
                  ^ (fb ? poly : '0);

endmodule

// File: rtl/crc32.sv
// Byte-serial Rocksoft-model CRC-32 engine: one byte per trigger,
// absorbed over 8 clocks, finalized on data_done.
module crc32
    import crc32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              crc_trigger,
    input  logic              data_done,
    input  logic [DATA_W-1:0] crc_32_in,
    input  logic              RefIn,
    input  logic              RefOut,
    input  logic              Xor_out,
    input  logic              Init,
    input  logic [CRC_W-1:0]  POLY_in,
    output logic              crc_busy,
    output logic              crc_finished,
    output logic [CRC_W-1:0]  crc_out32_xor
);

    state_t state;
    state_t state_nx;

    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] data_sr;
    logic [CRC_W-1:0]  poly_q;
    logic [CRC_W-1:0]  crc_reg;
    logic [CRC_W-1:0]  crc_step;
    logic [CRC_W-1:0]  out_q;
    logic              fin_q;

    logic accept;
    logic finalize;
    logic last_bit;
    logic [CRC_W-1:0] seed;
    logic [CRC_W-1:0] result;

    assign seed = Init ? CRC_ONES : '0;

    assign result = (RefOut ? rev32(crc_reg) : crc_reg)
                  ^ (Xor_out ? CRC_ONES : '0);

    crc32_bitstep u_bitstep (
        .crc_in   (crc_reg),
        .data_bit (data_sr[DATA_W-1]),
        .poly     (poly_q),
        .crc_nx   (crc_step)
    );

    // A trigger outranks data_done in IDLE; a level data_done
    // left high during SHIFT finalizes on the first IDLE cycle.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        finalize = 1'b0;
        last_bit = 1'b0;
        unique case (state)
            IDLE: begin
                if (crc_trigger) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                end else if (data_done) begin
                    finalize = 1'b1;
                    state_nx = DONE;
                end
            end
            SHIFT: begin
                last_bit = (bit_cnt == 3'd7);
                if (last_bit) begin
                    state_nx = IDLE;
                end
            end
            DONE: begin
                if (crc_trigger) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            data_sr <= '0;
            poly_q  <= '0;
            crc_reg <= seed;
            out_q   <= '0;
            fin_q   <= 1'b0;
        end else if (accept) begin
            data_sr <= RefIn ? rev8(crc_32_in) : crc_32_in;
            poly_q  <= POLY_in;
            bit_cnt <= '0;
            if (state == DONE) begin
                crc_reg <= seed;
                fin_q   <= 1'b0;
            end
        end else if (state == SHIFT) begin
            crc_reg <= crc_step;
            data_sr <= {data_sr[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
        end else if (finalize) begin
            out_q <= result;
            fin_q <= 1'b1;
        end
    end

    assign crc_busy      = (state == SHIFT);
    assign crc_finished  = fin_q;
    assign crc_out32_xor = out_q;

endmodule

// File: tb/tb_crc32.sv
// Table-driven bench for crc32: catalogue CRC check values with a
// scoreboard queue, plus handshake and reset corner sequences.
module tb_crc32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        crc_trigger = 1'b0;
    logic        data_done = 1'b0;
    logic [7:0]  crc_32_in = '0;
    logic        RefIn = 1'b0;
    logic        RefOut = 1'b0;
    logic        Xor_out = 1'b0;
    logic        Init = 1'b0;
    logic [31:0] POLY_in = '0;
    logic        crc_busy;
    logic        crc_finished;
    logic [31:0] crc_out32_xor;

    crc32 dut (
        .clk           (clk),
        .rst           (rst),
        .crc_trigger   (crc_trigger),
        .data_done     (data_done),
        .crc_32_in     (crc_32_in),
        .RefIn         (RefIn),
        .RefOut        (RefOut),
        .Xor_out       (Xor_out),
        .Init          (Init),
        .POLY_in       (POLY_in),
        .crc_busy      (crc_busy),
        .crc_finished  (crc_finished),
        .crc_out32_xor (crc_out32_xor)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        do_rst;
        logic [31:0] poly;
        logic        init;
        logic        refin;
        logic        refout;
        logic        xorout;
        int          nbytes;
        logic        glitch;
        logic        early;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [7];
    logic [7:0]  msg [9];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b,
                             input logic glitch,
                             input logic early,
                             input logic [31:0] exp);
        int busy_n;
        @(negedge clk);
        crc_trigger = 1'b1;
        crc_32_in   = b;
        @(negedge clk);
        crc_trigger = 1'b0;
        busy_n = 0;
        for (int s = 0; s < 10; s++) begin
            if (s > 0) @(negedge clk);
            if (s == 0) check("finished_clr", {31'd0, crc_finished}, 32'd0);
            busy_n += int'(crc_busy);
            if (glitch && s == 3) begin
                crc_trigger = 1'b1;
                crc_32_in   = 8'hAA;
            end
            if (glitch && s == 4) crc_trigger = 1'b0;
            if (early && s == 2) begin
                data_done = 1'b1;
                exp_q.push_back(exp);
            end
        end
        check("busy_len", busy_n, 32'd8);
        if (early) check("early_fin", {31'd0, crc_finished}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] want;
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                8'h36, 8'h37, 8'h38, 8'h39};
        vecs[0] = '{"iso_hdlc", 1, 32'h04C11DB7, 1, 1, 1, 1, 9, 0, 0,
                    32'hCBF43926};
        vecs[1] = '{"aixm", 0, 32'h814141AB, 0, 0, 0, 0, 9, 0, 0,
                    32'h3010BF7F};
        vecs[2] = '{"bzip2", 0, 32'h04C11DB7, 1, 0, 0, 1, 9, 0, 0,
                    32'hFC891918};
        vecs[3] = '{"mpeg2_early", 0, 32'h04C11DB7, 1, 0, 0, 0, 9, 0, 1,
                    32'h0376E6E7};
        vecs[4] = '{"jamcrc_glitch", 0, 32'h04C11DB7, 1, 1, 1, 0, 9, 1, 0,
                    32'h340BC6D9};
        vecs[5] = '{"zero_ref_xor", 1, 32'h04C11DB7, 1, 1, 1, 1, 0, 0, 0,
                    32'h00000000};
        vecs[6] = '{"zero_plain", 1, 32'h04C11DB7, 1, 0, 0, 0, 0, 0, 0,
                    32'hFFFFFFFF};

        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            POLY_in = vecs[v].poly;
            Init    = vecs[v].init;
            RefIn   = vecs[v].refin;
            RefOut  = vecs[v].refout;
            Xor_out = vecs[v].xorout;
            if (vecs[v].do_rst) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_busy", {31'd0, crc_busy}, 32'd0);
                check("rst_fin", {31'd0, crc_finished}, 32'd0);
                check("rst_out", crc_out32_xor, 32'd0);
            end
            for (int i = 0; i < vecs[v].nbytes; i++) begin
                send_byte(msg[i], vecs[v].glitch,
                          vecs[v].early && (i == 8), vecs[v].exp);
            end
            if (!data_done) begin
                @(negedge clk);
                data_done = 1'b1;
                exp_q.push_back(vecs[v].exp);
            end
            for (int w = 0; w < 20 && !crc_finished; w++) @(negedge clk);
            check({vecs[v].name, "_fin"}, {31'd0, crc_finished}, 32'd1);
            want = 32'hDEADBEEF;
            if (exp_q.size() > 0) want = exp_q.pop_front();
            check(vecs[v].name, crc_out32_xor, want);
            repeat (3) @(negedge clk);
            check({vecs[v].name, "_hold"}, crc_out32_xor, want);
            check({vecs[v].name, "_sticky"}, {31'd0, crc_finished}, 32'd1);
            data_done = 1'b0;
        end

        @(negedge clk);
        crc_trigger = 1'b1;
        crc_32_in   = 8'h31;
        @(negedge clk);
        crc_trigger = 1'b0;
        @(negedge clk);
        check("mid_busy", {31'd0, crc_busy}, 32'd1);
        check("mid_fin_clr", {31'd0, crc_finished}, 32'd0);
        check("mid_out_hold", crc_out32_xor, 32'hFFFFFFFF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, crc_busy}, 32'd0);
        check("abort_fin", {31'd0, crc_finished}, 32'd0);
        check("abort_out", crc_out32_xor, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_idle", {31'd0, crc_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
